anim_seq: RTL and testbench

Frame-index sequencer for the LED animation path. Generates the 7-bit frame index that drives the segment-pattern decoder, advancing one frame every DIV+1 clocks. Supports loop or one-shot playback, forward or reverse direction, and pause with single-step. Sits directly upstream of the frame decoder; `idx` connects straight to the decoder's 7-bit input.

---
 rtl/anim_seq.sv | 212 +++++++++++++++++++++
 tb/tb_anim_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/anim_seq.sv
// -----------------------------------------------------------------------------
// anim_seq -- frame-index sequencer for the LED animation path.
//
// Produces the 7-bit frame index consumed by the segment-pattern decoder and
// advances it once every div+1 clocks. Playback can loop or run once, count
// up or down, and be paused with single-frame stepping.
//
// Ports
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      pulse: (re)start playback from the first frame
//   pause  in   1      level: freeze playback while high
//   step   in   1      pulse: advance one frame, only while paused
//   rev    in   1      direction, captured on start (0 up, 1 down)
//   loop   in   1      1 = continuous, 0 = one-shot (live)
//   div    in   DIV_W  frame period minus one, in clocks (live)
//   idx    out  7      current frame index
//   tick   out  1      pulse in the cycle idx takes a new value
//   busy   out  1      playback active (running or held)
//   done   out  1      pulse when a one-shot sequence ends
//
// Build option
//   ANIM_SEQ_PINGPONG_EN  when defined, loop mode bounces at the endpoints
//                         (127 -> 126 going down, 0 -> 1 going up) instead
//                         of wrapping. One-shot playback is unaffected.
// -----------------------------------------------------------------------------
module anim_seq #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic             rev,
    input  logic             loop,
    input  logic [DIV_W-1:0] div,
    output logic [6:0]       idx,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [6:0] IDX_LAST  = 7'd127;
    localparam logic [6:0] IDX_FIRST = 7'd0;

    // Registered state
    state_t           state_r;
    logic [DIV_W-1:0] cnt_r;
    logic             dir_r;
    logic [6:0]       idx_r;
    logic             tick_r;
    logic             busy_r;
    logic             done_r;

    // Next-state values
    state_t           state_s;
    logic [DIV_W-1:0] cnt_s;
    logic             dir_s;
    logic [6:0]       idx_s;
    logic             tick_s;
    logic             busy_s;
    logic             done_s;

    // Advance helpers
    logic             adv_s;      // a frame advance is due this cycle
    logic             at_end_s;   // idx sits on the endpoint for the current direction
    logic [6:0]       adv_idx_s;  // index after a looping advance
    logic             adv_dir_s;  // direction after a looping advance

    // Target index/direction of an advance, including the endpoint wrap or bounce.
    always_comb begin
        adv_dir_s = dir_r;
        if (dir_r) begin
            at_end_s = (idx_r == IDX_FIRST);
        end else begin
            at_end_s = (idx_r == IDX_LAST);
        end

        if (!at_end_s) begin
            if (dir_r) begin
                adv_idx_s = idx_r - 7'd1;
            end else begin
                adv_idx_s = idx_r + 7'd1;
            end
        end else begin
`ifdef ANIM_SEQ_PINGPONG_EN
            // Bounce: reverse direction and step one frame back inward.
            adv_dir_s = ~dir_r;
            if (dir_r) begin
                adv_idx_s = IDX_FIRST + 7'd1;
            end else begin
                adv_idx_s = IDX_LAST - 7'd1;
            end
`else
            // Wrap to the opposite endpoint; direction is kept.
            if (dir_r) begin
                adv_idx_s = IDX_LAST;
            end else begin
                adv_idx_s = IDX_FIRST;
            end
`endif
        end
    end

    // Next-state logic: start beats everything else, then pause/step/count.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        dir_s   = dir_r;
        idx_s   = idx_r;
        tick_s  = 1'b0;
        done_s  = 1'b0;
        adv_s   = 1'b0;

        if (start) begin
            // A pause level in this cycle is deliberately not looked at.
            state_s = ST_RUN;
            dir_s   = rev;
            cnt_s   = {DIV_W{1'b0}};
            tick_s  = 1'b1;
            if (rev) begin
                idx_s = IDX_LAST;
            end else begin
                idx_s = IDX_FIRST;
            end
        end else begin
            case (state_r)
                ST_RUN, ST_HOLD: begin
                    if (pause) begin
                        // Counter is frozen; a step is only honoured once held.
                        state_s = ST_HOLD;
                        if ((state_r == ST_HOLD) && step) begin
                            adv_s = 1'b1;
                            cnt_s = {DIV_W{1'b0}};
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end else begin
                        // Releasing pause counts in the same cycle, so the
                        // frame period is made of exactly div+1 unpaused clocks.
                        // >= lets a div lowered below cnt advance immediately.
                        state_s = ST_RUN;
                        if (cnt_r >= div) begin
                            adv_s = 1'b1;
                            cnt_s = {DIV_W{1'b0}};
                        end else begin
                            cnt_s = cnt_r + DIV_W'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    // step and pause are ignored; idx keeps its last value.
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = {DIV_W{1'b0}};
                end
            endcase

            if (adv_s) begin
                if (at_end_s && !loop) begin
                    // One-shot end: idx holds, no tick, single done pulse.
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    idx_s  = adv_idx_s;
                    dir_s  = adv_dir_s;
                    tick_s = 1'b1;
                end
            end else begin
                tick_s = 1'b0;
            end
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {DIV_W{1'b0}};
            dir_r   <= 1'b0;
            idx_r   <= 7'd0;
            tick_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            dir_r   <= dir_s;
            idx_r   <= idx_s;
            tick_r  <= tick_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign idx  = idx_r;
    assign tick = tick_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_anim_seq.sv
// -----------------------------------------------------------------------------
// tb_anim_seq -- scoreboard bench for anim_seq.
// A driver applies one input vector per clock, runs a frame-level reference
// model and queues the expected outputs tagged with the edge they belong to.
// A monitor on the falling edge pops and compares every due entry.
// -----------------------------------------------------------------------------
module tb_anim_seq;

    localparam int DIV_W = 24;

    logic             clk;
    logic             rst;
    logic             start;
    logic             pause;
    logic             step;
    logic             rev;
    logic             loop;
    logic [DIV_W-1:0] div;
    logic [6:0]       idx;
    logic             tick;
    logic             busy;
    logic             done;

    anim_seq #(.DIV_W(DIV_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .pause (pause),
        .step  (step),
        .rev   (rev),
        .loop  (loop),
        .div   (div),
        .idx   (idx),
        .tick  (tick),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned stamp;
        logic [6:0]  idx;
        logic        tick;
        logic        busy;
        logic        done;
        string       tag;
    } exp_t;

    exp_t        expq[$];
    int unsigned edge_cnt = 0;
    int          errors   = 0;
    int          checks   = 0;
    string       phase    = "reset";

    // Reference model: frame number, direction, playing/held flags and the
    // number of unpaused clocks spent on the current frame.
    int     m_frame  = 0;
    bit     m_dir    = 1'b0;
    bit     m_active = 1'b0;
    bit     m_hold   = 1'b0;
    longint m_el     = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void model_step(input bit r, input bit s, input bit p,
                                       input bit st, input bit rv, input bit lp,
                                       input logic [DIV_W-1:0] d, output exp_t e);
        bit adv;
        int nxt;
        adv    = 1'b0;
        e.tick = 1'b0;
        e.done = 1'b0;
        if (r) begin
            m_frame = 0; m_dir = 1'b0; m_active = 1'b0; m_hold = 1'b0; m_el = 0;
        end else if (s) begin
            m_dir = rv; m_frame = rv ? 127 : 0; m_el = 0;
            m_active = 1'b1; m_hold = 1'b0; e.tick = 1'b1;
        end else if (m_active) begin
            if (p) begin
                if (m_hold && st) begin
                    adv = 1'b1; m_el = 0;
                end
                m_hold = 1'b1;
            end else begin
                m_hold = 1'b0;
                if (m_el >= longint'(d)) begin
                    adv = 1'b1; m_el = 0;
                end else begin
                    m_el = m_el + 1;
                end
            end
            if (adv) begin
                nxt = m_dir ? m_frame - 1 : m_frame + 1;
                if (nxt < 0 || nxt > 127) begin
                    if (!lp) begin
                        m_active = 1'b0; e.done = 1'b1;
                    end else begin
`ifdef ANIM_SEQ_PINGPONG_EN
                        m_dir   = !m_dir;
                        m_frame = m_dir ? 126 : 1;
`else
                        m_frame = (nxt + 128) % 128;
`endif
                        e.tick = 1'b1;
                    end
                end else begin
                    m_frame = nxt; e.tick = 1'b1;
                end
            end
        end
        e.idx  = 7'(m_frame);
        e.busy = m_active;
    endfunction

    // Apply the current inputs for one clock and queue the expected result.
    task automatic cyc();
        exp_t e;
        model_step(rst, start, pause, step, rev, loop, div, e);
        e.stamp = edge_cnt + 1;
        e.tag   = phase;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic run_until_frame(input int f, input int budget);
        for (int i = 0; i < budget && m_frame != f; i++) cyc();
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    // Monitor: compare every expectation whose edge has passed.
    always @(negedge clk) begin
        exp_t e;
        while (expq.size() > 0 && expq[0].stamp <= edge_cnt) begin
            e = expq.pop_front();
            checks = checks + 1;
            if ({idx, tick, busy, done} !== {e.idx, e.tick, e.busy, e.done}) begin
                errors = errors + 1;
                $display("FAIL %s edge=%0d got idx=%0d tick=%b busy=%b done=%b expected idx=%0d tick=%b busy=%b done=%b",
                         e.tag, e.stamp, idx, tick, busy, done, e.idx, e.tick, e.busy, e.done);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; step = 1'b0;
        rev = 1'b0; loop = 1'b1; div = 24'd3;
        run(3);
        rst = 1'b0;
        run(2);

        // Forward loop with wrap.
        phase = "fwd_loop";
        div = 24'd3; loop = 1'b1; rev = 1'b0;
        pulse_start();
        run(4 * 130);

        // One-shot forward, one frame per clock.
        phase = "oneshot_fwd";
        div = 24'd0; loop = 1'b0;
        pulse_start();
        run(135);

        // Pause, hold, single step, release.
        phase = "pause_step";
        div = 24'd9; loop = 1'b1; rev = 1'b0;
        pulse_start();
        run_until_frame(5, 200);
        pause = 1'b1;
        run(30);
        step = 1'b1; cyc(); step = 1'b0;
        pause = 1'b0;
        run(25);

        // Reverse one-shot.
        phase = "rev_oneshot";
        rev = 1'b1; loop = 1'b0; div = 24'd1;
        pulse_start();
        rev = 1'b0;
        run(270);

        // Restart and reset in mid-run; pause together with start.
        phase = "midrun";
        div = 24'd0; loop = 1'b1;
        pulse_start();
        run_until_frame(40, 200);
        pause = 1'b1; start = 1'b1; cyc(); start = 1'b0; pause = 1'b0;
        run_until_frame(40, 200);
        rst = 1'b1; cyc(); rst = 1'b0;
        step = 1'b1; pause = 1'b1; run(3);
        step = 1'b0; pause = 1'b0; run(3);

`ifdef ANIM_SEQ_PINGPONG_EN
        phase = "pingpong";
        loop = 1'b1; div = 24'd0; rev = 1'b0;
        pulse_start();
        run(400);
`endif

        // Randomized mix including live div/loop changes.
        phase = "random";
        rev = 1'b0; loop = 1'b1; pause = 1'b0; div = 24'd1;
        pulse_start();
        for (int i = 0; i < 5000; i++) begin
            start = ($urandom_range(0, 149) == 0);
            rst   = ($urandom_range(0, 999) == 0);
            step  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            rev = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) loop = ~loop;
            if ($urandom_range(0, 39) == 0) div = 24'($urandom_range(0, 4));
            cyc();
        end
        rst = 1'b0; start = 1'b0; step = 1'b0; pause = 1'b0;
        run(2);

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (expq.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
